// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined main memory between I-cache fills, D-cache fills and
// D-cache write-through stores, and raises the pipeline stall while any of them is outstanding.
module mem_fill_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 8,
    parameter int CNT_W         = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr_req,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [DATA_W-1:0] dcache_wr_data,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              fill_we,
    output logic              fill_sel,
    output logic [CNT_W-1:0]  fill_word,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_tag_we,
    output logic              icache_fill_done,
    output logic              dcache_fill_done,
    output logic              wr_ack,
    output logic              mem_stall
);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    localparam logic [CNT_W:0]   WORDS     = (CNT_W+1)'(WORDS_PER_BLK);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);

    state_t            state_q, state_d;
    logic              fill_sel_q, fill_sel_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;

    logic issuing;
    logic last_recv;

    assign issuing   = (state_q == FILL) && (issue_cnt_q < WORDS);
    assign last_recv = (state_q == FILL) && mem_data_valid && (recv_cnt_q == LAST_WORD);

    function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:CNT_W+1], {(CNT_W+1){1'b0}}};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fill_sel_q  <= 1'b0;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_sel_q  <= fill_sel_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    // Returned words are counted rather than timed, so memory latency never appears here.
    always_comb begin
        state_d     = state_q;
        fill_sel_d  = fill_sel_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        case (state_q)
            IDLE: begin
                if (dcache_miss) begin
                    state_d    = FILL;
                    fill_sel_d = 1'b1;
                    base_d     = blk_base(dcache_addr);
                end else if (icache_miss && !dcache_wr_req) begin
                    state_d    = FILL;
                    fill_sel_d = 1'b0;
                    base_d     = blk_base(icache_addr);
                end
            end
            FILL: begin
                if (issuing) issue_cnt_d = issue_cnt_q + 1'b1;
                if (mem_data_valid) recv_cnt_d = recv_cnt_q + 1'b1;
                if (last_recv) begin
                    state_d     = IDLE;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, including the store path that decodes raw inputs.
    always_comb begin
        mem_en           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        fill_we          = 1'b0;
        fill_word        = '0;
        fill_data        = '0;
        fill_tag_we      = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;
        wr_ack           = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (!dcache_miss && dcache_wr_req) begin
                        mem_en    = 1'b1;
                        mem_wr    = 1'b1;
                        mem_addr  = dcache_wr_addr;
                        mem_wdata = dcache_wr_data;
                        wr_ack    = 1'b1;
                    end
                end
                FILL: begin
                    if (issuing) begin
                        mem_en   = 1'b1;
                        mem_addr = {base_q[ADDR_W-1:CNT_W+1], issue_cnt_q[CNT_W-1:0], 1'b0};
                    end
                    if (mem_data_valid) begin
                        fill_we   = 1'b1;
                        fill_word = recv_cnt_q;
                        fill_data = mem_rdata;
                    end
                    if (last_recv) begin
                        fill_tag_we      = 1'b1;
                        icache_fill_done = !fill_sel_q;
                        dcache_fill_done = fill_sel_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fill_sel  = fill_sel_q;
    assign mem_stall = icache_miss | dcache_miss | (state_q == FILL) | (dcache_wr_req & ~wr_ack);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed and randomized bench for mem_fill_arbiter against a 4-cycle pipelined memory model.
module tb_mem_fill_arbiter;

    logic        clk;
    logic        rst;
    logic        icache_miss;
    logic [15:0] icache_addr;
    logic        dcache_miss;
    logic [15:0] dcache_addr;
    logic        dcache_wr_req;
    logic [15:0] dcache_wr_addr;
    logic [15:0] dcache_wr_data;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        fill_we;
    logic        fill_sel;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        fill_tag_we;
    logic        icache_fill_done;
    logic        dcache_fill_done;
    logic        wr_ack;
    logic        mem_stall;

    mem_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_addr(icache_addr),
        .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
        .fill_tag_we(fill_tag_we), .icache_fill_done(icache_fill_done),
        .dcache_fill_done(dcache_fill_done), .wr_ack(wr_ack), .mem_stall(mem_stall)
    );

    int          checks;
    int          failures;
    int          cyc;
    bit          rdv [8];
    logic [15:0] rda [8];
    bit          stray;
    logic [15:0] salt;
    logic [15:0] dm_addr_g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ salt ^ {a[7:0], a[15:8]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory: a read issued in cycle c returns its word in cycle c+4.
    task automatic adv();
        int s;
        if (mem_en && !mem_wr) begin
            rdv[(cyc + 4) % 8] = 1'b1;
            rda[(cyc + 4) % 8] = mem_addr;
        end
        @(posedge clk);
        #1;
        cyc++;
        s = cyc % 8;
        mem_data_valid = rdv[s] | stray;
        mem_rdata      = rdv[s] ? mdata(rda[s]) : 16'($urandom);
        rdv[s] = 1'b0;
        stray  = 1'b0;
    endtask

    task automatic quiet_chk(input logic exp_stall);
        chk("q_mem_en", 32'(mem_en), 32'(0));
        chk("q_mem_wr", 32'(mem_wr), 32'(0));
        chk("q_mem_addr", 32'(mem_addr), 32'(0));
        chk("q_fill_we", 32'(fill_we), 32'(0));
        chk("q_fill_data", 32'(fill_data), 32'(0));
        chk("q_tag_we", 32'(fill_tag_we), 32'(0));
        chk("q_done", 32'({icache_fill_done, dcache_fill_done}), 32'(0));
        chk("q_wr_ack", 32'(wr_ack), 32'(0));
        chk("q_stall", 32'(mem_stall), 32'(exp_stall));
    endtask

    task automatic idle_chk(input logic exp_stall);
        #1;
        chk("idle_mem_en", 32'(mem_en), 32'(0));
        chk("idle_fill_we", 32'(fill_we), 32'(0));
        chk("idle_tag_we", 32'(fill_tag_we), 32'(0));
        chk("idle_done", 32'({icache_fill_done, dcache_fill_done}), 32'(0));
        chk("idle_stall", 32'(mem_stall), 32'(exp_stall));
        adv();
    endtask

    task automatic store_chk(input logic [15:0] a, input logic [15:0] d, input logic exp_stall);
        #1;
        chk("st_mem_en", 32'(mem_en), 32'(1));
        chk("st_mem_wr", 32'(mem_wr), 32'(1));
        chk("st_addr", 32'(mem_addr), 32'(a));
        chk("st_wdata", 32'(mem_wdata), 32'(d));
        chk("st_wr_ack", 32'(wr_ack), 32'(1));
        chk("st_stall", 32'(mem_stall), 32'(exp_stall));
        adv();
    endtask

    // Called at the start of FILL cycle 0; returns at the start of the first cycle after done.
    task automatic fill_chk(input logic sel, input logic [15:0] base, input int wr_at,
                            input int dm_at, input int drop_at, input int abort_at,
                            output int ncyc);
        int k;
        int r;
        logic [15:0] ea;
        k = 0;
        r = 0;
        ncyc = 20;
        for (int n = 0; n < 20; n++) begin
            if (n == abort_at) begin
                rst = 1'b0;
                icache_miss = 1'b0;
                dcache_miss = 1'b0;
                #1;
                quiet_chk(1'b0);
                ncyc = n;
                break;
            end
            if (n == wr_at) begin
                dcache_wr_req  = 1'b1;
                dcache_wr_addr = 16'h4000;
                dcache_wr_data = 16'hBEEF;
            end
            if (n == dm_at) begin
                dcache_miss = 1'b1;
                dcache_addr = dm_addr_g;
            end
            if (drop_at >= 0 && n >= drop_at) begin
                icache_miss = 1'b0;
                dcache_miss = 1'b0;
                icache_addr = 16'($urandom);
                dcache_addr = 16'($urandom);
            end
            #1;
            chk("fill_mem_en", 32'(mem_en), 32'(k < 8));
            if (k < 8) begin
                ea = 16'(base + 16'(2 * k));
                chk("fill_rd_addr", 32'(mem_addr), 32'(ea));
                chk("fill_mem_wr", 32'(mem_wr), 32'(0));
                k++;
            end
            chk("fill_stall", 32'(mem_stall), 32'(1));
            chk("fill_wr_ack", 32'(wr_ack), 32'(0));
            if (mem_data_valid) begin
                ea = 16'(base + 16'(2 * r));
                chk("fill_we", 32'(fill_we), 32'(1));
                chk("fill_word", 32'(fill_word), 32'(r));
                chk("fill_data", 32'(fill_data), 32'(mdata(ea)));
                chk("fill_sel", 32'(fill_sel), 32'(sel));
                chk("fill_tag_we", 32'(fill_tag_we), 32'(r == 7));
                chk("fill_idone", 32'(icache_fill_done), 32'(r == 7 && !sel));
                chk("fill_ddone", 32'(dcache_fill_done), 32'(r == 7 && sel));
                r++;
            end else begin
                chk("fill_we_novld", 32'(fill_we), 32'(0));
                chk("fill_tag_novld", 32'(fill_tag_we), 32'(0));
            end
            adv();
            if (r == 8) begin
                ncyc = n + 1;
                break;
            end
        end
    endtask

    initial begin
        int nc;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] ib;
        logic [15:0] ib2;
        logic        s;
        checks = 0;
        failures = 0;
        cyc = 0;
        stray = 1'b0;
        salt = 16'($urandom);
        for (int i = 0; i < 8; i++) begin
            rdv[i] = 1'b0;
            rda[i] = '0;
        end
        mem_data_valid = 1'b0;
        mem_rdata = 16'($urandom);
        dcache_miss = 1'b0;
        dcache_addr = '0;
        icache_addr = '0;
        dcache_wr_addr = 16'($urandom);
        dcache_wr_data = 16'($urandom);

        // Reset held with requests present: outputs quiet, stall follows the request inputs.
        rst = 1'b0;
        icache_miss = 1'b1;
        dcache_wr_req = 1'b1;
        #3;
        quiet_chk(1'b1);
        icache_miss = 1'b0;
        dcache_wr_req = 1'b0;
        #1;
        chk("rst_stall_clear", 32'(mem_stall), 32'(0));
        @(posedge clk);
        #3;
        rst = 1'b1;
        adv();
        idle_chk(1'b0);

        // I miss at 0x1236.
        icache_miss = 1'b1;
        icache_addr = 16'h1236;
        idle_chk(1'b1);
        fill_chk(1'b0, 16'h1230, -1, -1, -1, -1, nc);
        chk("i_fill_cycles", 32'(nc), 32'(12));
        icache_miss = 1'b0;
        idle_chk(1'b0);

        // Simultaneous I and D miss: D first, then I back-to-back.
        ib = 16'($urandom);
        icache_miss = 1'b1;
        icache_addr = ib;
        dcache_miss = 1'b1;
        dcache_addr = 16'hA00A;
        idle_chk(1'b1);
        fill_chk(1'b1, 16'hA000, -1, -1, -1, -1, nc);
        chk("d_fill_cycles", 32'(nc), 32'(12));
        dcache_miss = 1'b0;
        idle_chk(1'b1);
        fill_chk(1'b0, {ib[15:4], 4'h0}, -1, -1, -1, -1, nc);
        chk("i2_fill_cycles", 32'(nc), 32'(12));
        icache_miss = 1'b0;
        idle_chk(1'b0);

        // Store and D miss arrive during an I fill; a second I miss is queued behind them.
        ib = 16'($urandom);
        dm_addr_g = 16'($urandom);
        icache_miss = 1'b1;
        icache_addr = ib;
        idle_chk(1'b1);
        fill_chk(1'b0, {ib[15:4], 4'h0}, 3, 5, -1, -1, nc);
        chk("i3_fill_cycles", 32'(nc), 32'(12));
        ib2 = 16'($urandom);
        icache_addr = ib2;
        idle_chk(1'b1);
        fill_chk(1'b1, {dm_addr_g[15:4], 4'h0}, -1, -1, -1, -1, nc);
        chk("d2_fill_cycles", 32'(nc), 32'(12));
        dcache_miss = 1'b0;
        store_chk(16'h4000, 16'hBEEF, 1'b1);
        dcache_wr_req = 1'b0;
        idle_chk(1'b1);
        fill_chk(1'b0, {ib2[15:4], 4'h0}, -1, -1, -1, -1, nc);
        chk("i4_fill_cycles", 32'(nc), 32'(12));
        icache_miss = 1'b0;
        idle_chk(1'b0);

        // Miss dropped mid-fill with address inputs scrambled: fill still completes.
        ib = 16'($urandom);
        icache_miss = 1'b1;
        icache_addr = ib;
        idle_chk(1'b1);
        fill_chk(1'b0, {ib[15:4], 4'h0}, -1, -1, 2, -1, nc);
        chk("drop_fill_cycles", 32'(nc), 32'(12));
        idle_chk(1'b0);

        // Reset at FILL cycle 6, late returns ignored, then a fresh fill from word 0.
        a = 16'($urandom);
        dcache_miss = 1'b1;
        dcache_addr = a;
        idle_chk(1'b1);
        fill_chk(1'b1, {a[15:4], 4'h0}, -1, -1, -1, 6, nc);
        chk("abort_cycle", 32'(nc), 32'(6));
        adv();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) idle_chk(1'b0);
        ib = 16'($urandom);
        icache_miss = 1'b1;
        icache_addr = ib;
        idle_chk(1'b1);
        fill_chk(1'b0, {ib[15:4], 4'h0}, -1, -1, -1, -1, nc);
        chk("post_rst_fill_cycles", 32'(nc), 32'(12));
        icache_miss = 1'b0;
        idle_chk(1'b0);

        // Stray valid in IDLE, then a fill at the top of the address space.
        stray = 1'b1;
        adv();
        chk("stray_vld_seen", 32'(mem_data_valid), 32'(1));
        idle_chk(1'b0);
        dcache_miss = 1'b1;
        dcache_addr = 16'hFFF7;
        idle_chk(1'b1);
        fill_chk(1'b1, 16'hFFF0, -1, -1, -1, -1, nc);
        chk("top_fill_cycles", 32'(nc), 32'(12));
        dcache_miss = 1'b0;
        idle_chk(1'b0);

        // Randomized stores and fills.
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = 16'($urandom);
                d = 16'($urandom);
                dcache_wr_req = 1'b1;
                dcache_wr_addr = a;
                dcache_wr_data = d;
                store_chk(a, d, 1'b0);
                dcache_wr_req = 1'b0;
            end
            a = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            if (s) begin
                dcache_miss = 1'b1;
                dcache_addr = a;
            end else begin
                icache_miss = 1'b1;
                icache_addr = a;
            end
            idle_chk(1'b1);
            fill_chk(s, {a[15:4], 4'h0}, -1, -1, -1, -1, nc);
            chk("rnd_fill_cycles", 32'(nc), 32'(12));
            icache_miss = 1'b0;
            dcache_miss = 1'b0;
            idle_chk(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Sequences the single shared 4-cycle-latency, pipelined main memory between I-cache block fills, D-cache block fills and D-cache write-through stores.
- Runs the block-fill state machine: issues 8 word reads and steers the returned data into the selected cache's data/tag arrays.
- Produces the memory-stall signal that freezes the pipeline alongside the hazard unit's PC/IF-ID write-enables.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, memory word width
WORDS_PER_BLK, 8, words per cache block (power of 2; block = 2*WORDS_PER_BLK bytes)
CNT_W, 3, log2(WORDS_PER_BLK)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
icache_miss  in  1  I-cache miss; level, held until fill done
icache_addr  in  ADDR_W  missing I-fetch byte address
dcache_miss  in  1  D-cache miss; level, held until fill done
dcache_addr  in  ADDR_W  missing data byte address
dcache_wr_req  in  1  write-through store request; level, held until wr_ack
dcache_wr_addr  in  ADDR_W  store byte address
dcache_wr_data  in  DATA_W  store data
mem_data_valid  in  1  memory read data valid
mem_rdata  in  DATA_W  memory read data
mem_en  out  1  memory access enable
mem_wr  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
fill_we  out  1  write fill_data into selected cache data array
fill_sel  out  1  0=I-cache, 1=D-cache
fill_word  out  CNT_W  word index within the block
fill_data  out  DATA_W  equals mem_rdata
fill_tag_we  out  1  final word: write tag, set valid
icache_fill_done  out  1  one-cycle pulse
dcache_fill_done  out  1  one-cycle pulse
wr_ack  out  1  one-cycle pulse, store issued
mem_stall  out  1  pipeline freeze request

Behaviour:
- States: IDLE, FILL. Registers: state, fill_sel, base address, issue_cnt (CNT_W+1 bits), recv_cnt (CNT_W bits).
- Reset (rst=0, async): state=IDLE, all counters 0, fill_sel=0. All outputs 0 except mem_stall (mirrors the miss inputs combinationally).
- IDLE arbitration, fixed priority, evaluated each cycle: dcache_miss > dcache_wr_req > icache_miss.
  - dcache_miss: at the edge, fill_sel=1, base={dcache_addr[ADDR_W-1:CNT_W+1], zeros}, go FILL.
  - dcache_wr_req, no D miss: same cycle, mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data, wr_ack=1. Stay IDLE. One store per cycle max.
  - icache_miss only: fill_sel=0, base from icache_addr, go FILL.
- FILL issue phase, while issue_cnt<WORDS_PER_BLK:
  - mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt.
  - issue_cnt increments each cycle: one read per cycle, 8 consecutive cycles, no gaps.
- FILL receive (concurrent with issue): each cycle with mem_data_valid=1 gives fill_we=1, fill_word=recv_cnt, fill_data=mem_rdata; recv_cnt increments.
- Returned data is counted, not timed; the controller does not model latency.
- recv_cnt==WORDS_PER_BLK-1 with mem_data_valid: fill_tag_we=1, the done pulse for fill_sel, counters cleared, next state IDLE.
- With 4-cycle memory, word i data returns at FILL cycle i+4. Last word at FILL cycle 11; miss to IDLE = 13 cycles.
- mem_data_valid in IDLE: ignored, no fill_we.
- mem_stall = icache_miss | dcache_miss | (state==FILL) | (dcache_wr_req & ~wr_ack).
- Simultaneous I and D miss: D filled first. I fill starts the cycle after D done (back-to-back; icache_miss still high).
- Store during FILL: held, wr_ack=0 until IDLE. Served before a pending I miss, after a pending D miss.
- Miss deasserted mid-fill: fill completes anyway. Base/fill_sel are latched, so input changes during FILL have no effect.
- Reset mid-fill: immediate IDLE, partial fill abandoned, no done/tag pulse. Memory valids that arrive after reset are ignored.
- Addresses wrap modulo 2^ADDR_W; the block base is always aligned, so no carry out of the block.

Test Plan:
- Reset: rst=0 mid-traffic → all outputs 0 asynchronously. After release with no requests → mem_en=0, mem_stall=0.
- I miss at icache_addr=0x1236 → reads 0x1230..0x123E, one per cycle. Returned words written with fill_word 0..7, fill_tag_we+icache_fill_done on the 8th valid, 13 cycles total.
- I miss and D miss (dcache_addr=0xA00A) same cycle → D fill of 0xA000..0xA00E first, then I fill starts the next cycle. fill_sel 1 then 0.
- Store (addr 0x4000, data 0xBEEF) during an I fill → no wr_ack until IDLE. Then a single cycle mem_wr=1, addr 0x4000, data 0xBEEF, wr_ack=1, ahead of any queued I miss.
- rst=0 at FILL cycle 6 → IDLE. Late valids produce no fill_we. A new miss restarts from word 0.
- Stray mem_data_valid in IDLE → no fill_we. Miss at 0xFFF0 → addresses 0xFFF0..0xFFFE, no wrap.
